// File: rtl/jacobi_pkg.sv
// jacobi_pkg: definitions shared by the Jacobi-solver Y-matrix change path.
//   - ENTRY_W and the bit positions of the change-entry fields
//     (row, col, real, img) inside one change-list SRAM word
//   - the FP24 zero-test mask and helper (sign bit ignored, so +0 and -0 match)
//   - chg_feed_state_t, the state encoding of chg_list_feeder
package jacobi_pkg;

  localparam int ENTRY_W  = 80;

  localparam int ROW_LSB  = 64;
  localparam int ROW_W    = 16;
  localparam int COL_LSB  = 48;
  localparam int COL_W    = 16;
  localparam int REAL_LSB = 24;
  localparam int REAL_W   = 24;
  localparam int IMG_LSB  = 0;
  localparam int IMG_W    = 24;

  // FP24: bit 23 is the sign; everything below it must be zero for +-0.
  localparam logic [23:0] FP24_MAG_MASK = 24'h7F_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ADV   = 3'd4,
    ST_FIN   = 3'd5
  } chg_feed_state_t;

  function automatic logic isFp24Zero(input logic [23:0] value);
    return (value & FP24_MAG_MASK) == 24'h0;
  endfunction

endpackage

// File: rtl/chg_list_feeder_if.sv
// chg_list_feeder_if: bundle between the change-list feeder, the change-list
// SRAM read port, the controller that starts a pass, and the Y-update block.
//   in_start / in_chgCount   pass start pulse and entry count
//   op_chgReadAddr/En        SRAM read request; in_chgReadData returns a cycle later
//   op_chg* / op_chgValid    presented entry and its valid flag
//   in_chgDone               completion pulse from the Y write-back path
//   op_busy / op_allDone     pass status; op_allDone pulses once per pass
//   op_entryIdx/op_skipCount index of the presented entry, entries skipped
//   dbgState                 current feeder FSM state (observation only)
// Modports: master = feeder side, slave = environment side.
//
// Handshake: op_chgValid is raised with a new entry and then op_chg* and
// op_entryIdx stay frozen. A one-cycle in_chgDone sampled while the entry is
// held retires it; op_chgValid drops on the next cycle. in_chgDone seen at
// any other time has no effect.
interface chg_list_feeder_if
  import jacobi_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int ENTRY_W = 80
);
  logic                in_start;
  logic [ADDR_W:0]     in_chgCount;
  logic [ENTRY_W-1:0]  in_chgReadData;
  logic                in_chgDone;
  logic [ADDR_W-1:0]   op_chgReadAddr;
  logic                op_chgReadEn;
  logic [15:0]         op_chgRow;
  logic [15:0]         op_chgCol;
  logic [23:0]         op_chgReal;
  logic [23:0]         op_chgImg;
  logic                op_chgValid;
  logic                op_busy;
  logic                op_allDone;
  logic [ADDR_W-1:0]   op_entryIdx;
  logic [ADDR_W:0]     op_skipCount;
  chg_feed_state_t     dbgState;

  modport master (
    input  in_start, in_chgCount, in_chgReadData, in_chgDone,
    output op_chgReadAddr, op_chgReadEn, op_chgRow, op_chgCol, op_chgReal,
           op_chgImg, op_chgValid, op_busy, op_allDone, op_entryIdx,
           op_skipCount, dbgState
  );

  modport slave (
    output in_start, in_chgCount, in_chgReadData, in_chgDone,
    input  op_chgReadAddr, op_chgReadEn, op_chgRow, op_chgCol, op_chgReal,
           op_chgImg, op_chgValid, op_busy, op_allDone, op_entryIdx,
           op_skipCount, dbgState
  );
endinterface

// File: rtl/chg_list_feeder.sv
// chg_list_feeder: walks the change-list SRAM and presents one entry at a
// time to the Y-update block, holding it until the write-back reports done.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset, clears all state and outputs
//   bus    chg_list_feeder_if.master (start/count, SRAM read, entry outputs,
//          done handshake, status and debug state)
// Build option: CHG_FEEDER_SKIP_ZERO_EN -- when defined, entries whose real
// and img are both +-0 are latched but not presented and are counted in
// op_skipCount; when undefined every entry is presented and op_skipCount
// stays 0.
module chg_list_feeder
  import jacobi_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int ENTRY_W = jacobi_pkg::ENTRY_W
) (
  input  logic              clock,
  input  logic              reset,
  chg_list_feeder_if.master bus
);

  chg_feed_state_t     state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W:0]     count;
  logic [ADDR_W:0]     skipCount;
  logic [ADDR_W:0]     ptrNext;
  logic [ENTRY_W-1:0]  rdData;

  logic                readEn;
  logic [15:0]         chgRow;
  logic [15:0]         chgCol;
  logic [23:0]         chgReal;
  logic [23:0]         chgImg;
  logic                chgValid;
  logic                busy;
  logic                allDone;
  logic [ADDR_W-1:0]   entryIdx;

  assign rdData  = bus.in_chgReadData;
  // One bit wider than ptr so a full list of 2^ADDR_W entries ends cleanly.
  assign ptrNext = {1'b0, ptr} + {{ADDR_W{1'b0}}, 1'b1};

`ifdef CHG_FEEDER_SKIP_ZERO_EN
  logic entryZero;
  assign entryZero = isFp24Zero(rdData[REAL_LSB +: REAL_W]) &&
                     isFp24Zero(rdData[IMG_LSB +: IMG_W]);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      count     <= '0;
      skipCount <= '0;
      readEn    <= 1'b0;
      chgRow    <= '0;
      chgCol    <= '0;
      chgReal   <= '0;
      chgImg    <= '0;
      chgValid  <= 1'b0;
      busy      <= 1'b0;
      allDone   <= 1'b0;
      entryIdx  <= '0;
    end else begin
      // Strobes are asserted only on the transition into their state.
      readEn  <= 1'b0;
      allDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_start) begin
            count     <= bus.in_chgCount;
            ptr       <= '0;
            skipCount <= '0;
            busy      <= 1'b1;
            if (bus.in_chgCount == '0) begin
              allDone <= 1'b1;
              state   <= ST_FIN;
            end else begin
              readEn <= 1'b1;
              state  <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state <= ST_LATCH;
        end
        ST_LATCH: begin
          chgRow   <= rdData[ROW_LSB +: ROW_W];
          chgCol   <= rdData[COL_LSB +: COL_W];
          chgReal  <= rdData[REAL_LSB +: REAL_W];
          chgImg   <= rdData[IMG_LSB +: IMG_W];
          entryIdx <= ptr;
`ifdef CHG_FEEDER_SKIP_ZERO_EN
          if (entryZero) begin
            skipCount <= skipCount + {{ADDR_W{1'b0}}, 1'b1};
            state     <= ST_ADV;
          end else begin
            chgValid <= 1'b1;
            state    <= ST_HOLD;
          end
`else
          chgValid <= 1'b1;
          state    <= ST_HOLD;
`endif
        end
        ST_HOLD: begin
          if (bus.in_chgDone) begin
            chgValid <= 1'b0;
            state    <= ST_ADV;
          end
        end
        ST_ADV: begin
          if (ptrNext == count) begin
            allDone <= 1'b1;
            state   <= ST_FIN;
          end else begin
            ptr    <= ptrNext[ADDR_W-1:0];
            readEn <= 1'b1;
            state  <= ST_READ;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.op_chgReadAddr = ptr;
  assign bus.op_chgReadEn   = readEn;
  assign bus.op_chgRow      = chgRow;
  assign bus.op_chgCol      = chgCol;
  assign bus.op_chgReal     = chgReal;
  assign bus.op_chgImg      = chgImg;
  assign bus.op_chgValid    = chgValid;
  assign bus.op_busy        = busy;
  assign bus.op_allDone     = allDone;
  assign bus.op_entryIdx    = entryIdx;
  assign bus.op_skipCount   = skipCount;
  assign bus.dbgState       = state;

endmodule
